popcount_window_accum: RTL and testbench
========================================

// Module: popcount_window_accum
// PURPOSE
//  Streaming population counter, the parametrised successor to our 4-input combinational ones-counter.
//  Accepts WIDTH-bit words over a valid/ready handshake and sums their set bits over a window of
//  WINDOW words, then presents the total, word count, threshold flag and saturation flag on a held
//  output handshake. Also exports a registered one-hot popcount of the last word accepted.
//  Sits between the input pad bank and the result/readout logic of the tile.
// PARAMETERS
//  WIDTH   4   bits per input word (>=1)
//  WINDOW  16  words per window (>=1)
//  CNT_W   8   width of accumulator / out_sum
//  THRESH  32  out_above asserted when out_sum >= THRESH
// PORTS
//  clk         in   1            clock, all state updates on rising edge
//  rst_n       in   1            reset, synchronous, active-low
//  ena         in   1            block enable; 0 freezes all state
//  in_valid    in   1            input word valid
//  in_ready    out  1            input can be accepted
//  in_data     in   WIDTH        input word
//  flush       in   1            close current window early
//  out_valid   out  1            result valid, held until accepted
//  out_ready   in   1            consumer accepts result
//  out_sum     out  CNT_W        saturating sum of set bits in window
//  out_words   out  clog2(WINDOW+1)  words contained in the result
//  out_above   out  1            out_sum >= THRESH
//  out_sat     out  1            accumulator saturated during window
//  last_onehot out  WIDTH+1      one-hot popcount of last accepted word
// BEHAVIOUR
//  - Interface: one clock (clk); reset synchronous, active-low (rst_n); sampled only on rising clk.
//  - Reset: acc=0, idx=0, sat=0, state=ACCUM; out_valid=0, out_sum=0, out_words=0, out_above=0,
//    out_sat=0, last_onehot=0. Reset mid-window or mid-hold discards everything, no result emitted.
//  - in_ready = ena & (state==ACCUM | out_ready). Accept = in_valid & in_ready.
//  - pop = number of 1s in in_data (0..WIDTH), combinational. On accept: last_onehot <= 1<<pop.
//  - acc_next = acc + pop, saturating at 2^CNT_W-1; saturating sets sat (sticky for the window).
//  - States: ACCUM (out_valid=0) and HOLD (out_valid=1).
//  - Window close (in ACCUM, or in HOLD in the same cycle the result is consumed):
//    accept with idx==WINDOW-1, or flush with in_ready high (with or without accept).
//    On close: out_sum<=acc_next, out_words<=idx+accept, out_sat<=sat|new_sat,
//    out_above<=(acc_next>=THRESH), acc<=0, idx<=0, sat<=0, state<=HOLD. Latency: result visible
//    the cycle after the closing word.
//  - Flush with idx==0 and no accept: no result (empty windows never emitted); flush ignored.
//  - Non-closing accept: acc<=acc_next, idx<=idx+1.
//  - HOLD: outputs stable while out_ready=0; in_ready=0 (back-pressure). out_valid&out_ready&ena
//    -> ACCUM unless a new close occurs the same cycle (then stays HOLD with new result, no bubble).
//  - ena=0: in_ready=0, out handshake ignored, all registers hold; out_valid stays as is.
//  - Widths: CNT_W need not cover WINDOW*WIDTH; saturation defines overflow. THRESH > 2^CNT_W-1
//    means out_above is never set.
// TESTING  (WIDTH=4, WINDOW=4, CNT_W=5, THRESH=8 unless stated)
//  - Reset: rst_n=0 two cycles with in_valid=1 -> in_ready follows ena, all outputs 0, no result.
//  - Window: 4'hF,4'h3,4'h1,4'h0 back-to-back, out_ready=1 -> next cycle out_valid=1, out_sum=7,
//    out_words=4, out_above=0, last_onehot=5'b00001.
//  - Back-pressure: full window of 4'hF, out_ready=0 for 5 cycles -> out_sum=16, out_above=1,
//    in_ready=0 and outputs stable throughout; out_ready=1 -> accepted, 5th word accepted same cycle.
//  - Flush: 4'h7,4'h1 then flush=1 alone -> out_sum=4, out_words=2; flush at idx==0 -> no output.
//  - Saturation: CNT_W=3, four 4'hF words -> out_sum=7, out_sat=1; next window 4'h1 x4 -> out_sat=0.
//  - Enable/mid-reset: ena=0 mid-window for 3 cycles with in_valid=1 -> idx/acc unchanged;
//    rst_n=0 in HOLD -> out_valid=0 next cycle, sum discarded.

Source files
------------

// File: rtl/popcount_window_accum.sv
// Windowed popcount accumulator: sums set bits of WIDTH-bit words over WINDOW words (or until flush).
// Latency: result registered, visible the cycle after the closing word; last_onehot one cycle after accept.
// Backpressure: in_ready drops while a result is held and out_ready is low; ena=0 stalls everything.
module popcount_window_accum #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8,
    parameter int THRESH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CNT_W-1:0]                 out_sum,
    output logic [$clog2(WINDOW+1)-1:0]      out_words,
    output logic                             out_above,
    output logic                             out_sat,
    output logic [WIDTH:0]                   last_onehot
);

    localparam int WORD_W = $clog2(WINDOW + 1);
    localparam int POP_W  = $clog2(WIDTH + 1);
    // One guard bit above the wider of accumulator and popcount so overflow is visible.
    localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    localparam logic [SUM_W-1:0]  ACC_MAX  = SUM_W'({CNT_W{1'b1}});
    localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(WINDOW - 1);
    localparam logic [31:0]       THRESH_U = 32'(THRESH);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    acc;
    logic [WORD_W-1:0]   idx;
    logic                sat;

    logic [POP_W-1:0]    pop;
    logic                accept;
    logic [SUM_W-1:0]    sum_wide;
    logic                new_sat;
    logic [CNT_W-1:0]    acc_next;
    logic [31:0]         acc_next_u;
    logic                close;

    // Count the ones in the incoming word.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(in_data[i]);
        end
    end

    // While holding, a word can only enter in the same cycle the held result leaves.
    assign in_ready  = ena & ((state == ACCUM) | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == HOLD);

    assign sum_wide   = SUM_W'(acc) + (accept ? SUM_W'(pop) : '0);
    assign new_sat    = (sum_wide > ACC_MAX);
    assign acc_next   = new_sat ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
    assign acc_next_u = 32'(acc_next);

    // A window closes on its last word, or on flush when it holds at least one word.
    assign close = in_ready & ((accept & (idx == LAST_IDX)) |
                               (flush & (accept | (idx != '0))));

    // Window accumulation, result capture and ACCUM/HOLD sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            idx         <= '0;
            sat         <= 1'b0;
            out_sum     <= '0;
            out_words   <= '0;
            out_above   <= 1'b0;
            out_sat     <= 1'b0;
            last_onehot <= '0;
        end else if (ena) begin
            if (accept) begin
                last_onehot <= (WIDTH + 1)'(1) << pop;
            end
            if (close) begin
                out_sum   <= acc_next;
                out_words <= idx + WORD_W'(accept);
                out_sat   <= sat | new_sat;
                out_above <= (acc_next_u >= THRESH_U);
                acc       <= '0;
                idx       <= '0;
                sat       <= 1'b0;
                state     <= HOLD;
            end else begin
                if (accept) begin
                    acc <= acc_next;
                    idx <= idx + WORD_W'(1);
                    sat <= sat | new_sat;
                end
                if ((state == HOLD) && out_ready) begin
                    state <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_window_accum.sv
// Bench for popcount_window_accum: two instances (CNT_W=5 and CNT_W=3) share one stimulus stream.
// Latency: outputs compared one step after each rising edge against a window-level reference model.
// Backpressure: out_ready and ena are driven by scenario tables and randomly.
module tb_popcount_window_accum;

    localparam int THRESH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy_a, vld_a, above_a, sat_a;
    logic [4:0] sum_a;
    logic [2:0] words_a;
    logic [4:0] oh_a;
    logic       rdy_b, vld_b, above_b, sat_b;
    logic [2:0] sum_b;
    logic [2:0] words_b;
    logic [4:0] oh_b;

    popcount_window_accum #(.WIDTH(4), .WINDOW(4), .CNT_W(5), .THRESH(THRESH)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .flush(flush), .out_valid(vld_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_words(words_a), .out_above(above_a), .out_sat(sat_a),
        .last_onehot(oh_a)
    );

    popcount_window_accum #(.WIDTH(4), .WINDOW(4), .CNT_W(3), .THRESH(THRESH)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .flush(flush), .out_valid(vld_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_words(words_b), .out_above(above_b), .out_sat(sat_b),
        .last_onehot(oh_b)
    );

    wire [16:0] act_a = {rdy_a, vld_a, sum_a, words_a, above_a, sat_a, oh_a};
    wire [14:0] act_b = {rdy_b, vld_b, sum_b, words_b, above_b, sat_b, oh_b};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the open window is a list of accepted words; totals are computed on close.
    logic [3:0] m_q[$];
    bit         m_hold = 1'b0;
    logic [4:0] m_sum_a = '0;
    logic [2:0] m_sum_b = '0;
    logic [2:0] m_words = '0;
    bit         m_above_a = 1'b0, m_above_b = 1'b0, m_sat_a = 1'b0, m_sat_b = 1'b0;
    logic [4:0] m_onehot = '0;
    logic       exp_rdy;
    logic [16:0] exp_a;
    logic [14:0] exp_b;

    function automatic logic [8:0] mk(bit r, bit e, bit v, logic [3:0] d, bit f, bit o);
        return {r, e, v, d, f, o};
    endfunction

    task automatic model_edge();
        int  total;
        int  cap_a;
        int  cap_b;
        bit  rdy;
        bit  acc;
        if (!rst_n) begin
            m_q.delete();
            m_hold = 1'b0;
            m_sum_a = '0; m_sum_b = '0; m_words = '0;
            m_above_a = 1'b0; m_above_b = 1'b0; m_sat_a = 1'b0; m_sat_b = 1'b0;
            m_onehot = '0;
        end else if (ena) begin
            rdy = !m_hold || out_ready;
            acc = in_valid && rdy;
            if (acc) begin
                m_q.push_back(in_data);
                m_onehot = 5'd1 << $countones(in_data);
            end
            if (rdy && (m_q.size() == 4 || (flush && m_q.size() > 0))) begin
                total = 0;
                foreach (m_q[k]) total += $countones(m_q[k]);
                cap_a = (total > 31) ? 31 : total;
                cap_b = (total > 7) ? 7 : total;
                m_sum_a = 5'(cap_a);
                m_sum_b = 3'(cap_b);
                m_sat_a = (total > 31);
                m_sat_b = (total > 7);
                m_above_a = (cap_a >= THRESH);
                m_above_b = (cap_b >= THRESH);
                m_words = 3'(m_q.size());
                m_q.delete();
                m_hold = 1'b1;
            end else if (m_hold && out_ready) begin
                m_hold = 1'b0;
            end
        end
        exp_rdy = ena && (!m_hold || out_ready);
        exp_a = {exp_rdy, m_hold, m_sum_a, m_words, m_above_a, m_sat_a, m_onehot};
        exp_b = {exp_rdy, m_hold, m_sum_b, m_words, m_above_b, m_sat_b, m_onehot};
    endtask

    // Drive one cycle of stimulus at the falling edge, advance the model, sample after the rising edge.
    task automatic apply(input logic [8:0] s);
        @(negedge clk);
        {rst_n, ena, in_valid, in_data, flush, out_ready} = s;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] seq[$];
        seq = {mk(0,1,1,4'hF,0,0), mk(0,0,1,4'hF,0,0), mk(1,1,0,4'h0,0,0)};
        foreach (seq[i]) begin
            apply(seq[i]);
            vectors++;
            if (act_a !== exp_a) begin miscompares++; $display("FAIL reset_a step %0d: got %h want %h", i, act_a, exp_a); end
            vectors++;
            if (act_b !== exp_b) begin miscompares++; $display("FAIL reset_b step %0d: got %h want %h", i, act_b, exp_b); end
            vectors++;
            if (i == 0 && {rdy_a, vld_a, sum_a, oh_a} !== {1'b1, 1'b0, 5'd0, 5'd0}) begin
                miscompares++; $display("FAIL reset_state: got rdy=%b vld=%b sum=%0d oh=%b want 1 0 0 00000", rdy_a, vld_a, sum_a, oh_a);
            end
            if (i == 1) begin
                vectors++;
                if (rdy_a !== 1'b0) begin miscompares++; $display("FAIL reset_ready_ena: got %b want 0", rdy_a); end
            end
        end
    endtask

    task automatic test_window();
        logic [8:0] seq[$];
        seq = {mk(1,1,1,4'hF,0,1), mk(1,1,1,4'h3,0,1), mk(1,1,1,4'h1,0,1), mk(1,1,1,4'h0,0,1),
               mk(1,1,0,4'h0,0,1)};
        foreach (seq[i]) begin
            apply(seq[i]);
            vectors++;
            if (act_a !== exp_a) begin miscompares++; $display("FAIL window_a step %0d: got %h want %h", i, act_a, exp_a); end
            vectors++;
            if (act_b !== exp_b) begin miscompares++; $display("FAIL window_b step %0d: got %h want %h", i, act_b, exp_b); end
            if (i == 3) begin
                vectors++;
                if ({vld_a, sum_a, words_a, above_a, oh_a} !== {1'b1, 5'd7, 3'd4, 1'b0, 5'b00001}) begin
                    miscompares++; $display("FAIL window_result: got vld=%b sum=%0d words=%0d above=%b oh=%b want 1 7 4 0 00001", vld_a, sum_a, words_a, above_a, oh_a);
                end
            end
            if (i == 4) begin
                vectors++;
                if (vld_a !== 1'b0) begin miscompares++; $display("FAIL window_consumed: got vld=%b want 0", vld_a); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] seq[$];
        seq = {mk(1,1,1,4'hF,0,0), mk(1,1,1,4'hF,0,0), mk(1,1,1,4'hF,0,0), mk(1,1,1,4'hF,0,0)};
        for (int k = 0; k < 5; k++) seq.push_back(mk(1,1,1,4'($urandom_range(15)),0,0));
        seq.push_back(mk(1,1,1,4'h1,0,1));
        seq.push_back(mk(1,1,0,4'h0,1,1));
        seq.push_back(mk(1,1,0,4'h0,0,1));
        foreach (seq[i]) begin
            apply(seq[i]);
            vectors++;
            if (act_a !== exp_a) begin miscompares++; $display("FAIL bp_a step %0d: got %h want %h", i, act_a, exp_a); end
            vectors++;
            if (act_b !== exp_b) begin miscompares++; $display("FAIL bp_b step %0d: got %h want %h", i, act_b, exp_b); end
            if (i >= 3 && i <= 8) begin
                vectors++;
                if ({rdy_a, vld_a, sum_a, above_a} !== {1'b0, 1'b1, 5'd16, 1'b1}) begin
                    miscompares++; $display("FAIL bp_hold step %0d: got rdy=%b vld=%b sum=%0d above=%b want 0 1 16 1", i, rdy_a, vld_a, sum_a, above_a);
                end
            end
            if (i == 9) begin
                vectors++;
                if ({vld_a, oh_a} !== {1'b0, 5'b00010}) begin
                    miscompares++; $display("FAIL bp_release: got vld=%b oh=%b want 0 00010", vld_a, oh_a);
                end
            end
            if (i == 10) begin
                vectors++;
                if ({vld_a, sum_a, words_a} !== {1'b1, 5'd1, 3'd1}) begin
                    miscompares++; $display("FAIL bp_fifth_word: got vld=%b sum=%0d words=%0d want 1 1 1", vld_a, sum_a, words_a);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [8:0] seq[$];
        seq = {mk(1,1,1,4'h7,0,1), mk(1,1,1,4'h1,0,1), mk(1,1,0,4'h0,1,1), mk(1,1,0,4'h0,0,1),
               mk(1,1,0,4'h0,1,1), mk(1,1,0,4'h0,0,1)};
        foreach (seq[i]) begin
            apply(seq[i]);
            vectors++;
            if (act_a !== exp_a) begin miscompares++; $display("FAIL flush_a step %0d: got %h want %h", i, act_a, exp_a); end
            vectors++;
            if (act_b !== exp_b) begin miscompares++; $display("FAIL flush_b step %0d: got %h want %h", i, act_b, exp_b); end
            if (i == 2) begin
                vectors++;
                if ({vld_a, sum_a, words_a} !== {1'b1, 5'd4, 3'd2}) begin
                    miscompares++; $display("FAIL flush_result: got vld=%b sum=%0d words=%0d want 1 4 2", vld_a, sum_a, words_a);
                end
            end
            if (i == 4) begin
                vectors++;
                if (vld_a !== 1'b0) begin miscompares++; $display("FAIL flush_empty: got vld=%b want 0", vld_a); end
            end
        end
    endtask

    task automatic test_saturation();
        logic [8:0] seq[$];
        seq = {mk(1,1,1,4'hF,0,1), mk(1,1,1,4'hF,0,1), mk(1,1,1,4'hF,0,1), mk(1,1,1,4'hF,0,1),
               mk(1,1,1,4'h1,0,1), mk(1,1,1,4'h1,0,1), mk(1,1,1,4'h1,0,1), mk(1,1,1,4'h1,0,1),
               mk(1,1,0,4'h0,0,1)};
        foreach (seq[i]) begin
            apply(seq[i]);
            vectors++;
            if (act_a !== exp_a) begin miscompares++; $display("FAIL sat_a step %0d: got %h want %h", i, act_a, exp_a); end
            vectors++;
            if (act_b !== exp_b) begin miscompares++; $display("FAIL sat_b step %0d: got %h want %h", i, act_b, exp_b); end
            if (i == 3) begin
                vectors++;
                if ({sum_b, sat_b, above_b, sum_a, sat_a} !== {3'd7, 1'b1, 1'b0, 5'd16, 1'b0}) begin
                    miscompares++; $display("FAIL sat_result: got sum_b=%0d sat_b=%b above_b=%b sum_a=%0d sat_a=%b want 7 1 0 16 0", sum_b, sat_b, above_b, sum_a, sat_a);
                end
            end
            if (i == 7) begin
                vectors++;
                if ({vld_b, sum_b, sat_b, words_b} !== {1'b1, 3'd4, 1'b0, 3'd4}) begin
                    miscompares++; $display("FAIL sat_cleared: got vld=%b sum_b=%0d sat_b=%b words=%0d want 1 4 0 4", vld_b, sum_b, sat_b, words_b);
                end
            end
        end
    endtask

    task automatic test_enable_reset();
        logic [8:0] seq[$];
        seq = {mk(1,1,1,4'h3,0,1), mk(1,1,1,4'h5,0,1),
               mk(1,0,1,4'hF,0,1), mk(1,0,1,4'hF,0,1), mk(1,0,1,4'hF,0,1),
               mk(1,1,1,4'h1,0,0), mk(1,1,1,4'h0,0,0),
               mk(1,0,0,4'h0,0,1), mk(1,1,0,4'h0,0,1),
               mk(1,1,1,4'hF,0,0), mk(1,1,1,4'hF,0,0), mk(1,1,1,4'hF,0,0), mk(1,1,1,4'hF,0,0),
               mk(0,1,0,4'h0,0,0), mk(1,1,0,4'h0,0,0)};
        foreach (seq[i]) begin
            apply(seq[i]);
            vectors++;
            if (act_a !== exp_a) begin miscompares++; $display("FAIL ena_a step %0d: got %h want %h", i, act_a, exp_a); end
            vectors++;
            if (act_b !== exp_b) begin miscompares++; $display("FAIL ena_b step %0d: got %h want %h", i, act_b, exp_b); end
            if (i >= 2 && i <= 4) begin
                vectors++;
                if ({rdy_a, vld_a} !== 2'b00) begin miscompares++; $display("FAIL ena_frozen step %0d: got rdy=%b vld=%b want 0 0", i, rdy_a, vld_a); end
            end
            if (i == 6) begin
                vectors++;
                if ({vld_a, sum_a, words_a} !== {1'b1, 5'd5, 3'd4}) begin
                    miscompares++; $display("FAIL ena_resume: got vld=%b sum=%0d words=%0d want 1 5 4", vld_a, sum_a, words_a);
                end
            end
            if (i == 7) begin
                vectors++;
                if (vld_a !== 1'b1) begin miscompares++; $display("FAIL ena_hold: got vld=%b want 1", vld_a); end
            end
            if (i == 13) begin
                vectors++;
                if ({vld_a, sum_a, words_a} !== {1'b0, 5'd0, 3'd0}) begin
                    miscompares++; $display("FAIL reset_in_hold: got vld=%b sum=%0d words=%0d want 0 0 0", vld_a, sum_a, words_a);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] s;
        for (int i = 0; i < 600; i++) begin
            s = mk($urandom_range(63) != 0, $urandom_range(7) != 0, $urandom_range(3) != 0,
                   4'($urandom_range(15)), $urandom_range(7) == 0, $urandom_range(2) != 0);
            apply(s);
            vectors++;
            if (act_a !== exp_a) begin miscompares++; $display("FAIL random_a cycle %0d: got %h want %h", i, act_a, exp_a); end
            vectors++;
            if (act_b !== exp_b) begin miscompares++; $display("FAIL random_b cycle %0d: got %h want %h", i, act_b, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_backpressure();
        test_flush();
        test_saturation();
        test_enable_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
